// File: rtl/pkt_router_mc.sv
// Multicast packet router: masked-key lookup into a registered lookup stage, then per-channel output registers.
// Latency: input handshake in cycle N gives pkt_out_vld_out in cycle N+2 when the outputs are free; counter strobes also appear in N+2.
// Backpressure: stage L holds a packet until every routed channel has loaded it or the blocked-output timeout fires.
//               pkt_in_rdy_out is asserted when stage L is empty or completes in the same cycle.
// Optional build macro PKT_ROUTER_DEFAULT_ROUTE_EN adds reg_dflt_route_in, which is used as the route on a table miss.
module pkt_router_mc #(
   parameter int PACKET_BITS  = 72,
   parameter int NUM_RREGS    = 16,
   parameter int KEY_LSB      = 8,
   parameter int NUM_CHANNELS = 8,
   parameter int WAIT_CYCLES  = 256,
   parameter int WAIT_BITS    = 16
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_RREGS-1:0][31:0]               reg_key_in,
   input  logic [NUM_RREGS-1:0][31:0]               reg_mask_in,
   input  logic [NUM_RREGS-1:0][NUM_CHANNELS-1:0]   reg_route_in,
`ifdef PKT_ROUTER_DEFAULT_ROUTE_EN
   input  logic [NUM_CHANNELS-1:0]                  reg_dflt_route_in,
`endif
   input  logic [PACKET_BITS-1:0]                   pkt_in_data_in,
   input  logic                                     pkt_in_vld_in,
   output logic                                     pkt_in_rdy_out,
   output logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0] pkt_out_data_out,
   output logic [NUM_CHANNELS-1:0]                  pkt_out_vld_out,
   input  logic [NUM_CHANNELS-1:0]                  pkt_out_rdy_in,
   output logic [1:0]                               rt_cnt_out
);

   // Stage L states.
   localparam logic [0:0] ST_EMPTY    = 1'b0;
   localparam logic [0:0] ST_DISPATCH = 1'b1;

   // Timeout threshold in counter width.
   localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(WAIT_CYCLES);
   localparam bit                   WAIT_EN    = (WAIT_CYCLES != 0);

   // Stage L state.
   logic [0:0]              l_state;
   logic [PACKET_BITS-1:0]  l_data;
   logic [NUM_CHANNELS-1:0] l_pend;
   logic [WAIT_BITS-1:0]    wait_cnt;

   // Lookup results for the packet currently offered at the input.
   logic [31:0]             lk_key;
   logic                    lk_hit;
   logic [NUM_CHANNELS-1:0] lk_route;
   logic [NUM_CHANNELS-1:0] cap_route;

   // Dispatch bookkeeping.
   logic                    in_dispatch;
   logic [NUM_CHANNELS-1:0] can_load;
   logic [NUM_CHANNELS-1:0] load;
   logic [NUM_CHANNELS-1:0] remain;
   logic                    done_zero;
   logic                    done_fwd;
   logic                    timed_out;
   logic                    l_done;
   logic                    accept;

   assign lk_key = pkt_in_data_in[KEY_LSB +: 32];

   // Priority lookup: scan from the top so the lowest-index hit is left standing.
   always_comb begin
      lk_hit   = 1'b0;
      lk_route = '0;
      for (int e = NUM_RREGS - 1; e >= 0; e--) begin
         if ((lk_key & reg_mask_in[e]) == reg_key_in[e]) begin
            lk_hit   = 1'b1;
            lk_route = reg_route_in[e];
         end
      end
   end

   // Route captured into stage L: the table route on a hit, otherwise the miss route.
   always_comb begin
      cap_route = lk_route;
      if (!lk_hit) begin
`ifdef PKT_ROUTER_DEFAULT_ROUTE_EN
         cap_route = reg_dflt_route_in;
`else
         cap_route = '0;
`endif
      end
   end

   // Dispatch decisions: which channels load this cycle and how stage L completes.
   always_comb begin
      in_dispatch = (l_state == ST_DISPATCH);
      // An output register can take a packet when it is empty or being drained this cycle.
      can_load    = ~pkt_out_vld_out | pkt_out_rdy_in;
      load        = in_dispatch ? (l_pend & can_load) : '0;
      remain      = l_pend & ~load;
      // A zero pending mask can only come from a miss or an empty route, never from delivery.
      done_zero   = in_dispatch && (l_pend == '0);
      done_fwd    = in_dispatch && (l_pend != '0) && (remain == '0);
      timed_out   = WAIT_EN && in_dispatch && !done_zero && !done_fwd && (wait_cnt == WAIT_LIMIT);
      l_done      = done_zero || done_fwd || timed_out;
   end

   assign pkt_in_rdy_out = !reset && (!in_dispatch || l_done);
   assign accept         = pkt_in_vld_in && pkt_in_rdy_out;

   // Stage L register: capture on handshake, shrink the pending mask as channels load, free on completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         l_state  <= ST_EMPTY;
         l_data   <= '0;
         l_pend   <= '0;
         wait_cnt <= '0;
      end else if (accept) begin
         l_state  <= ST_DISPATCH;
         l_data   <= pkt_in_data_in;
         l_pend   <= cap_route;
         wait_cnt <= '0;
      end else if (l_done) begin
         l_state  <= ST_EMPTY;
         l_pend   <= '0;
         wait_cnt <= '0;
      end else if (in_dispatch) begin
         l_pend   <= remain;
         // Any channel making progress restarts the blocked-output window.
         if (load != '0) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + WAIT_BITS'(1);
         end
      end
   end

   // Per-packet counter strobes: exactly one of drop/forward per completed packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         rt_cnt_out <= 2'b00;
      end else begin
         rt_cnt_out <= {done_fwd, done_zero || timed_out};
      end
   end

   // Output registers: load from stage L, hold while stalled, clear valid once consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_out_vld_out  <= '0;
         pkt_out_data_out <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (load[c]) begin
               pkt_out_vld_out[c]  <= 1'b1;
               pkt_out_data_out[c] <= l_data;
            end else if (pkt_out_rdy_in[c]) begin
               pkt_out_vld_out[c]  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pkt_router_mc.sv
// Randomized and directed bench for pkt_router_mc with a per-channel scoreboard and strobe accounting.
module tb_pkt_router_mc;

   localparam int PB = 72;
   localparam int NR = 16;
   localparam int KL = 8;
   localparam int NC = 8;
   localparam int WC = 16;
   localparam int WB = 16;
   localparam int SBD = 1024;

   localparam logic [1:0] M_RAND = 2'd0;
   localparam logic [1:0] M_ONE  = 2'd1;
   localparam logic [1:0] M_ZERO = 2'd2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NR-1:0][31:0]     t_key;
   logic [NR-1:0][31:0]     t_mask;
   logic [NR-1:0][NC-1:0]   t_route;
   logic [PB-1:0]           in_data;
   logic                    in_vld;
   logic                    in_rdy;
   logic [NC-1:0][PB-1:0]   out_data;
   logic [NC-1:0]           out_vld;
   logic [NC-1:0]           out_rdy;
   logic [1:0]              rt_cnt;
   logic [1:0]              rdy_mode [NC];
   logic [NC-1:0]           rand_rdy;
`ifdef PKT_ROUTER_DEFAULT_ROUTE_EN
   logic [NC-1:0]           dflt_route = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int drop_exp = 0;
   int fwd_exp  = 0;
   int drop_seen = 0;
   int fwd_seen  = 0;
   int cyc = 0;

   logic [PB-1:0] exp_mem [NC][SBD];
   int head [NC];
   int tail [NC];

   pkt_router_mc #(
      .PACKET_BITS(PB), .NUM_RREGS(NR), .KEY_LSB(KL),
      .NUM_CHANNELS(NC), .WAIT_CYCLES(WC), .WAIT_BITS(WB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .reg_key_in(t_key),
      .reg_mask_in(t_mask),
      .reg_route_in(t_route),
`ifdef PKT_ROUTER_DEFAULT_ROUTE_EN
      .reg_dflt_route_in(dflt_route),
`endif
      .pkt_in_data_in(in_data),
      .pkt_in_vld_in(in_vld),
      .pkt_in_rdy_out(in_rdy),
      .pkt_out_data_out(out_data),
      .pkt_out_vld_out(out_vld),
      .pkt_out_rdy_in(out_rdy),
      .rt_cnt_out(rt_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready per channel: forced high, forced low, or random with short low runs.
   always_comb begin
      out_rdy = '0;
      for (int c = 0; c < NC; c++) begin
         if (rdy_mode[c] == M_ONE)       out_rdy[c] = 1'b1;
         else if (rdy_mode[c] == M_ZERO) out_rdy[c] = 1'b0;
         else                            out_rdy[c] = rand_rdy[c];
      end
   end

   initial begin
      int run [NC];
      rand_rdy = '1;
      for (int c = 0; c < NC; c++) run[c] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < NC; c++) begin
            if (run[c] >= 3 || $urandom_range(0, 3) != 0) begin
               rand_rdy[c] = 1'b1;
               run[c] = 0;
            end else begin
               rand_rdy[c] = 1'b0;
               run[c] = run[c] + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference route: the first table entry whose masked key matches, else no channels.
   function automatic logic [NC-1:0] model_route(input logic [31:0] k);
      for (int e = 0; e < NR; e++) begin
         if ((k & t_mask[e]) == t_key[e]) return t_route[e];
      end
      return '0;
   endfunction

   // Monitor: every consumed output must be the next expected packet on that channel.
   always @(negedge clk) begin
      if (!reset) begin
         for (int c = 0; c < NC; c++) begin
            if (out_vld[c] && out_rdy[c]) begin
               if (head[c] == tail[c]) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_out ch%0d: got %0h expected nothing (cycle %0d)", c, out_data[c], cyc);
               end else begin
                  check($sformatf("ch%0d_data", c), out_data[c], exp_mem[c][head[c] % SBD]);
                  head[c] = head[c] + 1;
               end
            end
         end
         if (rt_cnt != 2'b00) check("strobe_onehot", PB'(rt_cnt == 2'b11), '0);
         drop_seen = drop_seen + int'(rt_cnt[0]);
         fwd_seen  = fwd_seen + int'(rt_cnt[1]);
      end
   end

   // Offer one packet, wait for the handshake, and record what should come out.
   task automatic send(input logic [PB-1:0] d, input bit expect_drop, output int waited);
      logic [NC-1:0] r;
      bit got;
      got = 1'b0;
      waited = 0;
      r = model_route(d[KL +: 32]);
      in_data = d;
      in_vld = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_rdy) got = 1'b1;
         else waited++;
         @(posedge clk);
         #1;
      end
      in_vld = 1'b0;
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_handshake: got no ready expected ready within 300 cycles (cycle %0d)", cyc);
      end else if (expect_drop || r == '0) begin
         drop_exp++;
      end else begin
         fwd_exp++;
         for (int c = 0; c < NC; c++) begin
            if (r[c]) begin
               exp_mem[c][tail[c] % SBD] = d;
               tail[c] = tail[c] + 1;
            end
         end
      end
   endtask

   task automatic clear_table();
      for (int e = 0; e < NR; e++) begin
         t_key[e]   = 32'h1;
         t_mask[e]  = 32'h0;
         t_route[e] = '0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [PB-1:0] mk_pkt(input logic [31:0] k);
      return {32'($urandom), k, 8'($urandom)};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish by 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int wsum;
      int snap;
      int pending;
      logic [PB-1:0] pa;
      logic [PB-1:0] pb;
      logic [31:0] k;
      logic [31:0] m;
      int idx;

      in_vld = 1'b0;
      in_data = '0;
      reset = 1'b1;
      for (int c = 0; c < NC; c++) begin
         rdy_mode[c] = M_ONE;
         head[c] = 0;
         tail[c] = 0;
      end
      clear_table();
      idle(3);
      @(negedge clk);
      check("rdy_in_reset", PB'(in_rdy), '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rdy_after_reset", PB'(in_rdy), PB'(1));
      check("vld_after_reset", PB'(out_vld), '0);
      check("data_after_reset", PB'(|out_data), '0);
      check("rtcnt_after_reset", PB'(rt_cnt), '0);
      idle(1);

      // Single unicast hit: latency and strobe timing.
      t_key[0] = 32'h00000100; t_mask[0] = 32'hFFFFFF00; t_route[0] = 8'h04;
      pa = {32'($urandom), 32'h000001AB, 8'h5A};
      send(pa, 1'b0, w);
      @(negedge clk);
      check("t1_vld_n1", PB'(out_vld[2]), '0);
      @(negedge clk);
      check("t1_vld_n2", PB'(out_vld[2]), PB'(1));
      check("t1_data", out_data[2], pa);
      check("t1_strobe", PB'(rt_cnt), PB'(2'b10));
      @(negedge clk);
      check("t1_strobe_end", PB'(rt_cnt), '0);
      idle(2);

      // Two hitting entries: the lower index wins.
      clear_table();
      t_key[0] = 32'h00002000; t_mask[0] = 32'hFFFFF000; t_route[0] = 8'h01;
      t_key[3] = 32'h00002300; t_mask[3] = 32'hFFFFFF00; t_route[3] = 8'h80;
      send(mk_pkt(32'h00002345), 1'b0, w);
      @(negedge clk);
      @(negedge clk);
      check("t2_ch0_vld", PB'(out_vld[0]), PB'(1));
      check("t2_ch7_silent", PB'(out_vld[7]), '0);
      idle(3);

      // Multicast with one blocked channel.
      clear_table();
      t_key[0] = 32'h00003000; t_mask[0] = 32'hFFFFF000; t_route[0] = 8'h02;
      t_key[1] = 32'h00004000; t_mask[1] = 32'hFFFFF000; t_route[1] = 8'h0F;
      rdy_mode[1] = M_ZERO;
      send(mk_pkt(32'h00003001), 1'b0, w);
      idle(3);
      snap = fwd_seen;
      send(mk_pkt(32'h00004001), 1'b0, w);
      wsum = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wsum += int'(in_rdy);
         if (i == 1) check("t3_fast_vld", PB'({out_vld[3], out_vld[2], out_vld[0]}), PB'(3'b111));
      end
      check("t3_rdy_low_while_pending", PB'(wsum), '0);
      @(posedge clk);
      #1;
      rdy_mode[1] = M_ONE;
      idle(6);
      check("t3_one_fwd", PB'(fwd_seen - snap), PB'(1));

      // Blocked-output timeout.
      clear_table();
      t_key[0] = 32'h00005000; t_mask[0] = 32'hFFFFF000; t_route[0] = 8'h20;
      t_key[1] = 32'h00006000; t_mask[1] = 32'hFFFFF000; t_route[1] = 8'h01;
      rdy_mode[5] = M_ZERO;
      pa = mk_pkt(32'h00005001);
      send(pa, 1'b0, w);
      idle(2);
      snap = drop_seen;
      send(mk_pkt(32'h00005002), 1'b1, w);
      send(mk_pkt(32'h00006001), 1'b0, w);
      check("t4_stall_cycles", PB'(w), PB'(WC));
      idle(3);
      check("t4_one_drop", PB'(drop_seen - snap), PB'(1));
      @(negedge clk);
      check("t4_ch5_held_vld", PB'(out_vld[5]), PB'(1));
      check("t4_ch5_held_data", out_data[5], pa);
      @(posedge clk);
      #1;
      rdy_mode[5] = M_ONE;
      idle(3);

      // Table misses, then back-to-back misses.
      clear_table();
      send(mk_pkt($urandom), 1'b0, w);
      idle(3);
      snap = drop_seen;
      wsum = 0;
      for (int i = 0; i < 100; i++) begin
         send(mk_pkt($urandom), 1'b0, w);
         wsum += w;
      end
      check("t5_no_stall", PB'(wsum), '0);
      idle(3);
      check("t5_drop_count", PB'(drop_seen - snap), PB'(100));

      // Reset while three channels are stalled mid-multicast.
      clear_table();
      t_key[0] = 32'h00007000; t_mask[0] = 32'hFFFFF000; t_route[0] = 8'h07;
      for (int c = 0; c < 3; c++) rdy_mode[c] = M_ZERO;
      send(mk_pkt(32'h00007001), 1'b0, w);
      send(mk_pkt(32'h00007002), 1'b0, w);
      idle(3);
      snap = drop_seen + fwd_seen;
      reset = 1'b1;
      fwd_exp--;
      for (int c = 0; c < NC; c++) head[c] = tail[c];
      idle(1);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) rdy_mode[c] = M_ONE;
      @(negedge clk);
      check("t6_vld_cleared", PB'(out_vld), '0);
      check("t6_rtcnt_cleared", PB'(rt_cnt), '0);
      check("t6_rdy_after", PB'(in_rdy), PB'(1));
      idle(3);
      check("t6_no_strobe", PB'(drop_seen + fwd_seen), PB'(snap));
      send(mk_pkt(32'h00007003), 1'b0, w);
      idle(4);

      // Randomized traffic against the reference model.
      for (int c = 0; c < NC; c++) rdy_mode[c] = M_RAND;
      for (int b = 0; b < 8; b++) begin
         for (int e = 0; e < NR; e++) begin
            case ($urandom_range(0, 2))
               0:       m = 32'hFFFFFF00;
               1:       m = 32'hFFFF0000;
               default: m = 32'hFFFFFFFF;
            endcase
            t_mask[e]  = m;
            t_key[e]   = $urandom & m;
            if ($urandom_range(0, 4) == 0) t_key[e] = t_key[e] | (~m & 32'h1);
            t_route[e] = ($urandom_range(0, 5) == 0) ? '0 : NC'($urandom);
         end
         for (int p = 0; p < 50; p++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            idx = $urandom_range(0, NR - 1);
            if ($urandom_range(0, 3) == 0) k = $urandom;
            else k = t_key[idx] | ($urandom & ~t_mask[idx]);
            send(mk_pkt(k), 1'b0, w);
         end
      end

      for (int c = 0; c < NC; c++) rdy_mode[c] = M_ONE;
      idle(30);
      check("total_drops", PB'(drop_seen), PB'(drop_exp));
      check("total_fwds", PB'(fwd_seen), PB'(fwd_exp));
      pending = 0;
      for (int c = 0; c < NC; c++) pending += tail[c] - head[c];
      check("scoreboard_drained", PB'(pending), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
